// File: rtl/survival_pkg.sv
// Shared types and constants for the survival time counter.
package survival_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  localparam logic [3:0]  BCD_MAX        = 4'd9;
  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: wraps 9->0, combinational carry-out for rippling into the next decade.
module bcd_digit
  import survival_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] value_o,
  output logic       carry_out_c
);

  logic [3:0] value_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= 4'd0;
    end else if (clr_i) begin
      value_q <= 4'd0;
    end else if (en_i) begin
      value_q <= (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
    end
  end

  assign value_o     = value_q;
  assign carry_out_c = en_i && (value_q == BCD_MAX);

endmodule

// File: rtl/survival_timer.sv
// Game survival timer: prescaler to TICK_HZ, run/stop FSM and a saturating 000-999 BCD count.
module survival_timer
  import survival_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned PRE_W   = 26
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       collided,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       tick,
  output logic       running,
  output logic       maxed
);

  localparam int unsigned      DIV      = CLK_HZ / TICK_HZ;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  state_e           state_q;
  logic [PRE_W-1:0] pre_q;
  logic             tick_q;
  logic             running_q;
  logic             maxed_q;

  logic [3:0] ones_v, tens_v, hund_v;
  logic       ones_carry, tens_carry, hund_carry_unused;
  logic       at_max, pre_wrap, is_run, clr_c, inc_c;

  // Saturation is caught here so the decade chain never sees an increment at 999.
  always_comb begin
    at_max   = (ones_v == BCD_MAX) && (tens_v == BCD_MAX) && (hund_v == BCD_MAX);
    pre_wrap = (pre_q == PRE_LAST);
    is_run   = (state_q == ST_RUNNING);
    clr_c    = start && !is_run;
    inc_c    = is_run && !collided && pre_wrap && !at_max;
  end

  bcd_digit u_ones (
    .clk_i      (CLOCK_50),
    .rst_ni     (resetn),
    .clr_i      (clr_c),
    .en_i       (inc_c),
    .value_o    (ones_v),
    .carry_out_c(ones_carry)
  );

  bcd_digit u_tens (
    .clk_i      (CLOCK_50),
    .rst_ni     (resetn),
    .clr_i      (clr_c),
    .en_i       (ones_carry),
    .value_o    (tens_v),
    .carry_out_c(tens_carry)
  );

  bcd_digit u_hundreds (
    .clk_i      (CLOCK_50),
    .rst_ni     (resetn),
    .clr_i      (clr_c),
    .en_i       (tens_carry),
    .value_o    (hund_v),
    .carry_out_c(hund_carry_unused)
  );

  // Run/stop FSM with the prescaler; collided outranks a same-cycle wrap.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      maxed_q   <= 1'b0;
    end else begin
      tick_q <= inc_c;
      case (state_q)
        ST_IDLE: begin
          pre_q <= '0;
          if (start) begin
            state_q   <= ST_RUNNING;
            running_q <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (collided) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
          end else if (pre_wrap) begin
            pre_q <= '0;
            if (at_max) begin
              state_q   <= ST_STOPPED;
              running_q <= 1'b0;
              maxed_q   <= 1'b1;
            end
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end
        ST_STOPPED: begin
          if (start) begin
            state_q   <= ST_RUNNING;
            running_q <= 1'b1;
            maxed_q   <= 1'b0;
            pre_q     <= '0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          pre_q     <= '0;
        end
      endcase
    end
  end

  assign ones     = ones_v;
  assign tens     = tens_v;
  assign hundreds = hund_v;
  assign tick     = tick_q;
  assign running  = running_q;
  assign maxed    = maxed_q;

endmodule

// File: tb/tb_survival_timer.sv
// Directed bench for survival_timer at CLK_HZ=8, TICK_HZ=1 (one tick every 8 edges).
module tb_survival_timer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       collided;
  logic [3:0] ones, tens, hundreds;
  logic       tick, running, maxed;
  logic [11:0] dig;

  int n_checks = 0;
  int n_fail   = 0;

  survival_timer #(
    .CLK_HZ (8),
    .TICK_HZ(1),
    .PRE_W  (4)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .start   (start),
    .collided(collided),
    .ones    (ones),
    .tens    (tens),
    .hundreds(hundreds),
    .tick    (tick),
    .running (running),
    .maxed   (maxed)
  );

  always #5 clk = ~clk;

  assign dig = {hundreds, tens, ones};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    collided = 1'b0;
    step(2);
    chk("rst_digits", dig, 12'h000);
    chk("rst_running", 12'(running), 12'h0);
    chk("rst_tick", 12'(tick), 12'h0);
    chk("rst_maxed", 12'(maxed), 12'h0);

    resetn   = 1'b1;
    collided = 1'b1;
    step(3);
    collided = 1'b0;
    chk("idle_collided_running", 12'(running), 12'h0);
    chk("idle_collided_digits", dig, 12'h000);

    // First run: entry edge E, first tick at E+8.
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_running", 12'(running), 12'h1);
    chk("start_digits", dig, 12'h000);
    chk("start_tick", 12'(tick), 12'h0);
    for (int i = 1; i < 8; i++) begin
      step(1);
      chk("pre_tick_digits", dig, 12'h000);
      chk("pre_tick_tick", 12'(tick), 12'h0);
    end
    step(1);
    chk("first_tick_digits", dig, 12'h001);
    chk("first_tick_tick", 12'(tick), 12'h1);
    step(1);
    chk("first_tick_pulse_end", 12'(tick), 12'h0);
    chk("first_tick_hold", dig, 12'h001);

    step(790);
    chk("before_100_digits", dig, 12'h099);
    chk("before_100_tick", 12'(tick), 12'h0);
    step(1);
    chk("ripple_100_digits", dig, 12'h100);
    chk("ripple_100_tick", 12'(tick), 12'h1);

    // start+collided while running stops; held into STOPPED restarts.
    start    = 1'b1;
    collided = 1'b1;
    step(1);
    chk("pair_run_running", 12'(running), 12'h0);
    chk("pair_run_digits", dig, 12'h100);
    chk("pair_run_tick", 12'(tick), 12'h0);
    step(1);
    start    = 1'b0;
    collided = 1'b0;
    chk("pair_stop_running", 12'(running), 12'h1);
    chk("pair_stop_digits", dig, 12'h000);
    chk("pair_stop_maxed", 12'(maxed), 12'h0);

    step(335);
    chk("count_041", dig, 12'h041);
    step(1);
    chk("count_042", dig, 12'h042);
    chk("count_042_tick", 12'(tick), 12'h1);
    step(7);
    chk("pre7_digits", dig, 12'h042);
    chk("pre7_running", 12'(running), 12'h1);
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("collide_wrap_digits", dig, 12'h042);
    chk("collide_wrap_tick", 12'(tick), 12'h0);
    chk("collide_wrap_running", 12'(running), 12'h0);
    step(19);
    chk("frozen_digits", dig, 12'h042);
    chk("frozen_running", 12'(running), 12'h0);
    chk("frozen_tick", 12'(tick), 12'h0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("restart_digits", dig, 12'h000);
    chk("restart_running", 12'(running), 12'h1);
    step(7);
    chk("restart_pre_tick", dig, 12'h000);
    step(1);
    chk("restart_first_tick", dig, 12'h001);
    chk("restart_first_tick_tick", 12'(tick), 12'h1);

    start = 1'b1;
    step(4);
    start = 1'b0;
    chk("start_ignored_digits", dig, 12'h001);
    chk("start_ignored_running", 12'(running), 12'h1);

    // Asynchronous reset between edges while tick is high at 057.
    step(444);
    chk("count_057", dig, 12'h057);
    chk("count_057_tick", 12'(tick), 12'h1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_digits", dig, 12'h000);
    chk("async_rst_tick", 12'(tick), 12'h0);
    chk("async_rst_running", 12'(running), 12'h0);
    chk("async_rst_maxed", 12'(maxed), 12'h0);
    step(1);
    resetn = 1'b1;
    step(20);
    chk("post_rst_idle_digits", dig, 12'h000);
    chk("post_rst_idle_running", 12'(running), 12'h0);

    start    = 1'b1;
    collided = 1'b1;
    step(1);
    start    = 1'b0;
    collided = 1'b0;
    chk("pair_idle_running", 12'(running), 12'h1);
    chk("pair_idle_digits", dig, 12'h000);

    // Run to saturation at 999.
    step(7991);
    chk("count_998", dig, 12'h998);
    step(1);
    chk("count_999", dig, 12'h999);
    chk("count_999_tick", 12'(tick), 12'h1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("sat_wait_tick", 12'(tick), 12'h0);
    end
    chk("sat_wait_running", 12'(running), 12'h1);
    chk("sat_wait_maxed", 12'(maxed), 12'h0);
    step(1);
    chk("sat_digits", dig, 12'h999);
    chk("sat_tick", 12'(tick), 12'h0);
    chk("sat_running", 12'(running), 12'h0);
    chk("sat_maxed", 12'(maxed), 12'h1);
    step(10);
    chk("sat_hold_digits", dig, 12'h999);
    chk("sat_hold_maxed", 12'(maxed), 12'h1);
    chk("sat_hold_tick", 12'(tick), 12'h0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("sat_restart_digits", dig, 12'h000);
    chk("sat_restart_maxed", 12'(maxed), 12'h0);
    chk("sat_restart_running", 12'(running), 12'h1);
    step(8);
    chk("sat_restart_tick_digits", dig, 12'h001);
    chk("sat_restart_tick", 12'(tick), 12'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
